// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared FSM state type and parameter defaults for hazard_ctrl
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int C_TIMEOUT_DEFAULT = 255;
  localparam int C_CNT_W_DEFAULT   = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, asynchronous active-low clear
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline stall/flush control with memory-wait timeout FSM
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = C_TIMEOUT_DEFAULT,
  parameter int CNT_W   = C_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int                  C_WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [C_WAIT_W-1:0] C_TIMEOUT = C_WAIT_W'(TIMEOUT);
  localparam logic [C_WAIT_W-1:0] C_ONE     = C_WAIT_W'(1);

  state_t              r_state, w_state_nxt;
  logic [C_WAIT_W-1:0] r_wait, w_wait_nxt;
  logic                w_memstall;
  logic                w_loaduse;

  assign w_memstall = MemReqM & ~MemReadyM;
  assign w_loaduse  = LoadE & RegWriteE & (RdE != 5'd0) &
                      ((RdE == Rs1D) | (RdE == Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    MemErr      = 1'b0;

    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_memstall) begin
          // Memory stall outranks branch and load-use; a held branch waits for release.
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
          if (r_state == RUN) begin
            w_state_nxt = MEM_WAIT;
            w_wait_nxt  = C_ONE;
          end else if (r_wait == C_TIMEOUT) begin
            w_state_nxt = ERROR;
          end else begin
            w_wait_nxt = r_wait + C_ONE;
          end
        end else begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (w_loaduse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      end
      ERROR: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        MemErr = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase

    if (!rst_n) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
      MemErr = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (StallF),
    .o_count (StallCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed vector table plus randomized model-checked stimulus
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_ctrl;

  localparam int P_TIMEOUT = 4;
  localparam int P_CNT_W   = 4;

  // Flag order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
  localparam logic [7:0] E_CLEAN = 8'b0000_0000;
  localparam logic [7:0] E_RST   = 8'b0000_1110;
  localparam logic [7:0] E_MEM   = 8'b1111_0010;
  localparam logic [7:0] E_LU    = 8'b1100_0100;
  localparam logic [7:0] E_BR    = 8'b0000_1100;
  localparam logic [7:0] E_ERR   = 8'b1111_0001;

  typedef struct {
    logic         rst_n;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         regw;
    logic         load;
    logic         pcsrc;
    logic         mreq;
    logic         mrdy;
    logic [7:0]   exp;
    logic [3:0]   cnt;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [4:0]         Rs1D = '0, Rs2D = '0, RdE = '0;
  logic               RegWriteE = 1'b0, LoadE = 1'b0, PCSrcE = 1'b0;
  logic               MemReqM = 1'b0, MemReadyM = 1'b0;
  logic               StallF, StallD, StallE, StallM;
  logic               FlushD, FlushE, FlushW, MemErr;
  logic [P_CNT_W-1:0] StallCount;

  int   checks = 0;
  int   errors = 0;
  int   m_run  = 0;
  int   m_cnt  = 0;
  bit   m_err  = 1'b0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .TIMEOUT (P_TIMEOUT),
    .CNT_W   (P_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCount (StallCount)
  );

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic regw, logic load, logic pcsrc, logic mreq, logic mrdy,
                              logic [7:0] exp, logic [3:0] cnt);
    vec_t v;
    v.rst_n = r;   v.rs1 = rs1;   v.rs2 = rs2;   v.rd = rd;
    v.regw = regw; v.load = load; v.pcsrc = pcsrc;
    v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;   v.cnt = cnt;
    return v;
  endfunction

  // Reference: stall priority from the rules; a memory run of TIMEOUT+1 cycles ends in error.
  function automatic logic [7:0] model_flags(vec_t v);
    bit memstall = v.mreq && !v.mrdy;
    bit lu = v.load && v.regw && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
    if (!v.rst_n) return E_RST;
    if (m_err)    return E_ERR;
    if (memstall) return E_MEM;
    if (v.pcsrc)  return E_BR;
    if (lu)       return E_LU;
    return E_CLEAN;
  endfunction

  function automatic void model_update(vec_t v, logic [7:0] flags);
    if (!v.rst_n) begin
      m_run = 0; m_err = 1'b0; m_cnt = 0;
      return;
    end
    if (!m_err) begin
      if (v.mreq && !v.mrdy) begin
        m_run = m_run + 1;
        if (m_run == P_TIMEOUT + 1) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    if (flags[7] && m_cnt < (2 ** P_CNT_W) - 1) m_cnt = m_cnt + 1;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    logic [7:0] got;
    rst_n = v.rst_n; Rs1D = v.rs1; Rs2D = v.rs2; RdE = v.rd;
    RegWriteE = v.regw; LoadE = v.load; PCSrcE = v.pcsrc;
    MemReqM = v.mreq; MemReadyM = v.mrdy;
    #2;
    got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};
    checks++;
    if ({got, StallCount} !== {v.exp, v.cnt}) begin
      errors++;
      $display("FAIL %s @%0t: got flags=%b count=%0d, expected flags=%b count=%0d",
               name, $time, got, StallCount, v.exp, v.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    //                r rs1 rs2 rd rw ld pc mq mr  exp      cnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,   0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_CLEAN, 0));
    tbl.push_back(mk(1, 5, 0, 5, 1, 1, 0, 0, 0, E_LU,    0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_CLEAN, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, E_CLEAN, 1));
    tbl.push_back(mk(1, 5, 0, 5, 1, 1, 1, 0, 0, E_BR,    1));
    tbl.push_back(mk(1, 3, 7, 7, 1, 1, 0, 0, 0, E_LU,    1));
    tbl.push_back(mk(1, 3, 7, 7, 1, 0, 0, 0, 0, E_CLEAN, 2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 5, 0, 5, 1, 1, 1, 1, 0, E_MEM, 4'(2 + i)));
    tbl.push_back(mk(1, 5, 0, 5, 1, 1, 1, 1, 1, E_BR,    5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_CLEAN, 5));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, 4'(5 + i)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR,   10));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, E_ERR,   11));
    tbl.push_back(mk(1, 5, 0, 5, 1, 1, 1, 0, 0, E_ERR,   12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,   0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_CLEAN, 0));
    tbl.push_back(mk(1, 5, 0, 5, 1, 1, 0, 0, 0, E_LU,    0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM,   1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM,   2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST,   0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, 4'(i)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR,   5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,   0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("table[%0d]", i));

    // Saturation: twenty consecutive stall cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++)
      run_vec(mk(1, 5, 0, 5, 1, 1, 0, 0, 0, E_LU, 4'((i < 15) ? i : 15)), "saturate");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_CLEAN, 15), "saturate_hold");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, 0), "saturate_clear");

    m_run = 0; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      v.rst_n = ($urandom_range(0, 99) >= 3);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.regw  = ($urandom_range(0, 3) != 0);
      v.load  = ($urandom_range(0, 1) != 0);
      v.pcsrc = ($urandom_range(0, 4) == 0);
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.mrdy  = ($urandom_range(0, 1) != 0);
      v.exp   = model_flags(v);
      v.cnt   = v.rst_n ? 4'(m_cnt) : 4'd0;
      run_vec(v, "random");
      model_update(v, v.exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum memory-wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-statistics counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports Rs1D and Rs2D, input, 5 each: source registers of the instruction in Decode.
REQ-006 SHALL have port RdE, input, 5: destination register in Execute.
REQ-007 SHALL have ports RegWriteE and LoadE, input, 1 each: Execute writes a register; Execute is a load.
REQ-008 SHALL have port PCSrcE, input, 1: taken branch or jump resolved in Execute.
REQ-009 SHALL have ports MemReqM and MemReadyM, input, 1 each: data-memory access pending in Memory; memory acknowledge.
REQ-010 SHALL have ports StallF, StallD, StallE and StallM, output, 1 each: hold enables for the Fetch, F/D, D/E and E/M registers.
REQ-011 SHALL have ports FlushD, FlushE and FlushW, output, 1 each: bubble insertion into F/D, D/E and M/W.
REQ-012 SHALL have port MemErr, output, 1: sticky memory-timeout error.
REQ-013 SHALL have port StallCount, output, CNT_W: saturating count of cycles with StallF=1.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT and ERROR.
REQ-015 SHALL define memstall = MemReqM & ~MemReadyM, combinational, in RUN and MEM_WAIT.
REQ-016 SHALL, on memstall, assert StallF, StallD, StallE, StallM and FlushW, with all other flushes 0, in the same cycle.
REQ-017 SHALL, in RUN with memstall, go to MEM_WAIT and set the wait counter to 1.
REQ-018 SHALL, in MEM_WAIT with memstall, increment the wait counter.
REQ-019 SHALL, in MEM_WAIT with MemReadyM=1, return to RUN and deassert the memory stalls in that same cycle.
REQ-020 SHALL go to ERROR when the wait counter equals TIMEOUT while memstall=1.
REQ-021 SHALL, in ERROR, hold all Stall outputs and MemErr at 1 and all flushes at 0 until reset, ignoring all inputs.
REQ-022 SHALL detect a load-use hazard, only when memstall=0, as LoadE & RegWriteE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
REQ-023 SHALL, on load-use, assert StallF, StallD and FlushE, with StallE and StallM at 0, for exactly one cycle per hazard.
REQ-024 SHALL, on PCSrcE=1 with memstall=0, assert FlushD and FlushE.
REQ-025 SHALL give branch priority over load-use when both occur: StallF=StallD=0, FlushD=FlushE=1.
REQ-026 SHALL apply a branch held in Execute during a memory stall on the release cycle, not earlier.
REQ-027 SHALL drive all Stall/Flush outputs combinationally from state and inputs, with no added latency.
REQ-028 SHALL increment StallCount each cycle StallF=1 and saturate at 2^CNT_W−1 with no wrap.
REQ-029 SHALL require the wait counter to be $clog2(TIMEOUT+1) bits wide, with no wrap before ERROR.

Reset
REQ-030 SHALL, while rst_n=0, force state RUN, wait counter 0, StallCount 0 and MemErr 0.
REQ-031 SHALL, while rst_n=0, drive all Stall outputs to 0 and FlushD, FlushE and FlushW to 1.
REQ-032 SHALL, on rst_n assertion mid-MEM_WAIT or in ERROR, abandon the wait immediately; the first cycle after release is RUN.

Structure
REQ-033 SHALL place the state enum and the TIMEOUT/CNT_W defaults in shared package hazard_pkg.
REQ-034 SHALL implement StallCount in one sub-module, sat_counter (parameterised width; inc and asynchronous clear).

Verification
REQ-035 SHALL cover load-use: LoadE=1, RegWriteE=1, RdE=5, Rs1D=5 -> one cycle of StallF=StallD=FlushE=1; the next cycle is clean after the bubble; StallCount=1.
REQ-036 SHALL cover x0: same as REQ-035 with RdE=0 and Rs1D=0 -> no stall, no flush.
REQ-037 SHALL cover branch plus load-use: PCSrcE=1 with a load-use hazard -> FlushD=FlushE=1, StallF=0.
REQ-038 SHALL cover memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> stalls for 3 cycles, released on the 4th; state returns to RUN; StallCount=3.
REQ-039 SHALL cover timeout: TIMEOUT=4 with MemReadyM held 0 -> ERROR after 4 wait cycles, MemErr=1 sticky; rst_n pulse -> MemErr=0, state RUN.
REQ-040 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> StallCount=15.
